// File: rtl/dsp19x2_acc_pkg.sv
// rtl/dsp19x2_acc_pkg.sv - shared widths, state type and lane split helper for the DSP19x2 lane accumulator
//
// Contents:
//   LANE_W_DEF / ACC_W_DEF / CNT_W_DEF : default lane, accumulator and block-counter widths
//   acc_state_t                        : block FSM states (IDLE, ACCUM)
//   lane_pair_t / split_lanes()        : unpack a packed DSP19x2 result into its lo and hi lanes
package dsp19x2_acc_pkg;

    localparam int LANE_W_DEF = 19;
    localparam int ACC_W_DEF  = 24;
    localparam int CNT_W_DEF  = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } acc_state_t;

    typedef struct packed {
        logic [LANE_W_DEF-1:0] hi;
        logic [LANE_W_DEF-1:0] lo;
    } lane_pair_t;

    // lo lane lives in the low half of the packed result, hi lane in the upper half
    function automatic lane_pair_t split_lanes(input logic [2*LANE_W_DEF-1:0] z);
        lane_pair_t p;
        p.lo = z[LANE_W_DEF-1:0];
        p.hi = z[2*LANE_W_DEF-1:LANE_W_DEF];
        return p;
    endfunction

endpackage

// File: rtl/dsp19x2_sat_acc_lane.sv
// rtl/dsp19x2_sat_acc_lane.sv - one saturating unsigned lane accumulator with sticky clamp flag
//
// Ports:
//   clk, reset : rising-edge clock, synchronous active-high reset
//   sample     : lane_in is a valid sample this cycle
//   start      : this sample opens a new block (running sum and sat flag are ignored)
//   done       : this sample closes the block (accumulator clears after it)
//   lane_in    : unsigned lane value, zero-extended to ACC_W
//   sum_next   : saturated sum including the current sample
//   sat_next   : sticky clamp flag including the current sample
module dsp19x2_sat_acc_lane
    import dsp19x2_acc_pkg::*;
#(
    parameter int LANE_W = LANE_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample,
    input  logic              start,
    input  logic              done,
    input  logic [LANE_W-1:0] lane_in,
    output logic [ACC_W-1:0]  sum_next,
    output logic              sat_next
);

    logic [ACC_W-1:0] acc_q;
    logic             sat_q;
    logic [ACC_W-1:0] base;
    logic             base_sat;
    logic [ACC_W:0]   raw;
    logic             clamp;

    always_comb begin
        // A block start behaves as a load: add onto zero with a clean flag.
        base     = start ? '0 : acc_q;
        base_sat = start ? 1'b0 : sat_q;
        raw      = {1'b0, base} + {{(ACC_W + 1 - LANE_W){1'b0}}, lane_in};
        clamp    = raw[ACC_W];
        sum_next = clamp ? {ACC_W{1'b1}} : raw[ACC_W-1:0];
        sat_next = base_sat | clamp;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
            sat_q <= 1'b0;
        end else if (sample) begin
            if (done) begin
                // Final value has been handed to the result register.
                acc_q <= '0;
                sat_q <= 1'b0;
            end else begin
                acc_q <= sum_next;
                sat_q <= sat_next;
            end
        end
    end

endmodule

// File: rtl/dsp19x2_lane_accumulator.sv
// rtl/dsp19x2_lane_accumulator.sv - per-block saturating sums of both DSP19x2 lanes behind a valid/ready result register
//
// Ports:
//   clk, reset        : rising-edge clock, synchronous active-high reset
//   z_in, z_valid     : packed two-lane DSP result and its qualifier
//   block_len         : samples per block, 0 selects 2^CNT_W; latched at block start
//   acc_lo, acc_hi    : block sums of the lo and hi lanes
//   sat_lo, sat_hi    : a clamp happened in the block shown on acc_lo / acc_hi
//   out_valid, out_ready : result handshake
//   busy              : a block of length > 1 is in progress
//   overrun           : sticky, a completed block was dropped because the result was not consumed
module dsp19x2_lane_accumulator
    import dsp19x2_acc_pkg::*;
#(
    parameter int LANE_W = LANE_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [2*LANE_W-1:0] z_in,
    input  logic                z_valid,
    input  logic [CNT_W-1:0]    block_len,
    output logic [ACC_W-1:0]    acc_lo,
    output logic [ACC_W-1:0]    acc_hi,
    output logic                sat_lo,
    output logic                sat_hi,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic                overrun
);

    acc_state_t       state;
    logic [CNT_W:0]   count;
    logic [CNT_W:0]   len_q;
    logic [CNT_W:0]   len_eff;
    logic [CNT_W:0]   len_sel;
    logic [CNT_W:0]   count_inc;
    logic             start;
    logic             done;
    logic             res_load;
    lane_pair_t       lanes;
    logic [ACC_W-1:0] sum_lo;
    logic [ACC_W-1:0] sum_hi;
    logic             sat_lo_next;
    logic             sat_hi_next;

    always_comb begin
        lanes     = split_lanes(z_in);
        start     = (state == IDLE);
        // Counter is one bit wider so a full 2^CNT_W block is representable.
        len_eff   = (block_len == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, block_len};
        len_sel   = start ? len_eff : len_q;
        count_inc = start ? {{CNT_W{1'b0}}, 1'b1} : count + 1'b1;
        done      = z_valid && (count_inc == len_sel);
        // A completion may land in the result register if it is empty or being drained now.
        res_load  = done && (!out_valid || out_ready);
    end

    dsp19x2_sat_acc_lane #(
        .LANE_W(LANE_W),
        .ACC_W (ACC_W)
    ) u_lane_lo (
        .clk     (clk),
        .reset   (reset),
        .sample  (z_valid),
        .start   (start),
        .done    (done),
        .lane_in (lanes.lo),
        .sum_next(sum_lo),
        .sat_next(sat_lo_next)
    );

    dsp19x2_sat_acc_lane #(
        .LANE_W(LANE_W),
        .ACC_W (ACC_W)
    ) u_lane_hi (
        .clk     (clk),
        .reset   (reset),
        .sample  (z_valid),
        .start   (start),
        .done    (done),
        .lane_in (lanes.hi),
        .sum_next(sum_hi),
        .sat_next(sat_hi_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            count     <= '0;
            len_q     <= '0;
            acc_lo    <= '0;
            acc_hi    <= '0;
            sat_lo    <= 1'b0;
            sat_hi    <= 1'b0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (z_valid) begin
                if (start) begin
                    len_q <= len_eff;
                end
                if (done) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    count <= '0;
                end else begin
                    state <= ACCUM;
                    busy  <= 1'b1;
                    count <= count_inc;
                end
            end

            if (res_load) begin
                acc_lo    <= sum_lo;
                acc_hi    <= sum_hi;
                sat_lo    <= sat_lo_next;
                sat_hi    <= sat_hi_next;
                out_valid <= 1'b1;
            end else if (done) begin
                // Result still pending and not accepted: keep it, flag the loss.
                overrun <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dsp19x2_lane_accumulator.sv
// tb/tb_dsp19x2_lane_accumulator.sv - directed self-checking bench for dsp19x2_lane_accumulator
module tb_dsp19x2_lane_accumulator;

    logic        clk;
    logic        reset;
    logic [37:0] z_in;
    logic        z_valid;
    logic [7:0]  block_len;
    logic [23:0] acc_lo;
    logic [23:0] acc_hi;
    logic        sat_lo;
    logic        sat_hi;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        overrun;

    int vectors;
    int errors;

    dsp19x2_lane_accumulator dut (
        .clk      (clk),
        .reset    (reset),
        .z_in     (z_in),
        .z_valid  (z_valid),
        .block_len(block_len),
        .acc_lo   (acc_lo),
        .acc_hi   (acc_hi),
        .sat_lo   (sat_lo),
        .sat_hi   (sat_hi),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy),
        .overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one cycle of input, then settle 1 time unit past the edge.
    task automatic cyc(input logic v, input logic [18:0] lo, input logic [18:0] hi);
        z_valid = v;
        z_in    = {hi, lo};
        @(posedge clk);
        #1;
        z_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(1'b0, 19'd0, 19'd0);
        cyc(1'b0, 19'd0, 19'd0);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        out_ready = 1'b0;
        block_len = 8'd4;
        do_reset();
        vectors++; if (acc_lo !== 24'd0)  begin errors++; $display("FAIL reset_acc_lo got %0h exp 0", acc_lo); end
        vectors++; if (acc_hi !== 24'd0)  begin errors++; $display("FAIL reset_acc_hi got %0h exp 0", acc_hi); end
        vectors++; if ({sat_lo, sat_hi} !== 2'b00) begin errors++; $display("FAIL reset_sat got %b exp 00", {sat_lo, sat_hi}); end
        vectors++; if ({out_valid, busy, overrun} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {out_valid, busy, overrun}); end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        block_len = 8'd4;
        cyc(1'b1, 19'd10, 19'd20);
        vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_rise got %b exp 1", busy); end
        block_len = 8'd2;   // must not affect the running block
        cyc(1'b1, 19'd10, 19'd20);
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_len_change got %b exp 0", out_valid); end
        cyc(1'b1, 19'd10, 19'd20);
        cyc(1'b1, 19'd10, 19'd20);
        vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", out_valid); end
        vectors++; if (acc_lo !== 24'd40) begin errors++; $display("FAIL basic_acc_lo got %0d exp 40", acc_lo); end
        vectors++; if (acc_hi !== 24'd80) begin errors++; $display("FAIL basic_acc_hi got %0d exp 80", acc_hi); end
        vectors++; if ({sat_lo, sat_hi} !== 2'b00) begin errors++; $display("FAIL basic_sat got %b exp 00", {sat_lo, sat_hi}); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_fall got %b exp 0", busy); end
        cyc(1'b0, 19'd0, 19'd0);
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_fall got %b exp 0", out_valid); end
    endtask

    task automatic test_saturate();
        out_ready = 1'b1;
        block_len = 8'd0;
        for (int i = 0; i < 255; i++) cyc(1'b1, 19'h7FFFF, 19'd1);
        vectors++; if ({busy, out_valid} !== 2'b10) begin errors++; $display("FAIL sat_255 got %b exp 10", {busy, out_valid}); end
        cyc(1'b1, 19'h7FFFF, 19'd1);
        vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sat_valid got %b exp 1", out_valid); end
        vectors++; if (acc_lo !== 24'hFFFFFF) begin errors++; $display("FAIL sat_acc_lo got %0h exp ffffff", acc_lo); end
        vectors++; if (acc_hi !== 24'd256) begin errors++; $display("FAIL sat_acc_hi got %0d exp 256", acc_hi); end
        vectors++; if ({sat_lo, sat_hi} !== 2'b10) begin errors++; $display("FAIL sat_flags got %b exp 10", {sat_lo, sat_hi}); end
        cyc(1'b0, 19'd0, 19'd0);
    endtask

    task automatic test_overrun();
        do_reset();
        out_ready = 1'b0;
        block_len = 8'd2;
        cyc(1'b1, 19'd1, 19'd0);
        cyc(1'b1, 19'd2, 19'd0);
        vectors++; if ({out_valid, overrun} !== 2'b10) begin errors++; $display("FAIL ovr_first got %b exp 10", {out_valid, overrun}); end
        vectors++; if (acc_lo !== 24'd3) begin errors++; $display("FAIL ovr_first_acc got %0d exp 3", acc_lo); end
        cyc(1'b1, 19'd3, 19'd0);
        cyc(1'b1, 19'd4, 19'd0);
        vectors++; if (acc_lo !== 24'd3) begin errors++; $display("FAIL ovr_held_acc got %0d exp 3", acc_lo); end
        vectors++; if ({out_valid, overrun} !== 2'b11) begin errors++; $display("FAIL ovr_set got %b exp 11", {out_valid, overrun}); end
        out_ready = 1'b1;
        cyc(1'b0, 19'd0, 19'd0);
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovr_drain got %b exp 0", out_valid); end
        cyc(1'b0, 19'd0, 19'd0);
        vectors++; if ({out_valid, overrun} !== 2'b01) begin errors++; $display("FAIL ovr_sticky got %b exp 01", {out_valid, overrun}); end
    endtask

    task automatic test_gaps();
        do_reset();
        out_ready = 1'b1;
        block_len = 8'd2;
        cyc(1'b1, 19'd5, 19'd0);
        cyc(1'b0, 19'd0, 19'd0);
        cyc(1'b1, 19'd6, 19'd0);
        vectors++; if ({out_valid, acc_lo} !== {1'b1, 24'd11}) begin errors++; $display("FAIL gap_first got %b/%0d exp 1/11", out_valid, acc_lo); end
        cyc(1'b0, 19'd0, 19'd0);
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL gap_fall got %b exp 0", out_valid); end
        cyc(1'b1, 19'd7, 19'd0);
        cyc(1'b0, 19'd0, 19'd0);
        cyc(1'b0, 19'd0, 19'd0);
        vectors++; if ({out_valid, busy} !== 2'b01) begin errors++; $display("FAIL gap_hold got %b exp 01", {out_valid, busy}); end
        cyc(1'b1, 19'd8, 19'd0);
        vectors++; if ({out_valid, acc_lo} !== {1'b1, 24'd15}) begin errors++; $display("FAIL gap_second got %b/%0d exp 1/15", out_valid, acc_lo); end
        vectors++; if (overrun !== 1'b0) begin errors++; $display("FAIL gap_overrun got %b exp 0", overrun); end
        cyc(1'b0, 19'd0, 19'd0);
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b0;
        block_len = 8'd2;
        cyc(1'b1, 19'd1, 19'd2);
        cyc(1'b1, 19'd1, 19'd2);
        vectors++; if ({out_valid, acc_lo, acc_hi} !== {1'b1, 24'd2, 24'd4}) begin errors++; $display("FAIL b2b_first got %b/%0d/%0d exp 1/2/4", out_valid, acc_lo, acc_hi); end
        cyc(1'b1, 19'd3, 19'd5);
        out_ready = 1'b1;
        cyc(1'b1, 19'd4, 19'd6);
        vectors++; if ({out_valid, acc_lo, acc_hi} !== {1'b1, 24'd7, 24'd11}) begin errors++; $display("FAIL b2b_swap got %b/%0d/%0d exp 1/7/11", out_valid, acc_lo, acc_hi); end
        vectors++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun got %b exp 0", overrun); end
        block_len = 8'd1;
        cyc(1'b1, 19'd9, 19'd0);
        vectors++; if ({out_valid, busy, acc_lo} !== {2'b10, 24'd9}) begin errors++; $display("FAIL b2b_len1_a got %b/%b/%0d exp 1/0/9", out_valid, busy, acc_lo); end
        cyc(1'b1, 19'd10, 19'd0);
        vectors++; if ({out_valid, acc_lo} !== {1'b1, 24'd10}) begin errors++; $display("FAIL b2b_len1_b got %b/%0d exp 1/10", out_valid, acc_lo); end
        cyc(1'b0, 19'd0, 19'd0);
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_fall got %b exp 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        block_len = 8'd4;
        cyc(1'b1, 19'd5, 19'd5);
        cyc(1'b1, 19'd5, 19'd5);
        cyc(1'b1, 19'd5, 19'd5);
        reset = 1'b1;
        cyc(1'b0, 19'd0, 19'd0);
        reset = 1'b0;
        vectors++; if ({acc_lo, acc_hi, sat_lo, sat_hi, out_valid, busy, overrun} !== 53'd0) begin errors++; $display("FAIL rst_mid_outputs got %0h/%0h/%b%b%b%b%b exp all 0", acc_lo, acc_hi, sat_lo, sat_hi, out_valid, busy, overrun); end
        for (int i = 0; i < 4; i++) cyc(1'b1, 19'd1, 19'd0);
        vectors++; if ({out_valid, acc_lo, acc_hi} !== {1'b1, 24'd4, 24'd0}) begin errors++; $display("FAIL rst_mid_result got %b/%0d/%0d exp 1/4/0", out_valid, acc_lo, acc_hi); end
    endtask

    initial begin
        vectors   = 0;
        errors    = 0;
        reset     = 1'b1;
        z_in      = '0;
        z_valid   = 1'b0;
        block_len = 8'd4;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_saturate();
        test_overrun();
        test_gaps();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
